// File: rtl/tag_wakeup_array.sv
// Purpose: operand-holding wakeup array; sources wake on matching CDB tags, ready entries issue lowest-first.
// Latency: wakeup/alloc visible one cycle after the edge; issue_valid/idx/vals are combinational from state.
// Backpressure: alloc_ready drops when all entries are valid; a stalled issue locks the presented entry until accepted.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   alloc_valid/alloc_ready              allocate a new entry (tags, ready bits, values per source)
//   cdb_valid/cdb_tag/cdb_data           CDB_N packed broadcast channels, channel k at [k*W +: W]
//   issue_valid/issue_ready              issue handshake, issue_idx/issue_val1/issue_val2 describe the entry
//   occupancy                            number of valid entries
module tag_wakeup_array #(
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 4,
    parameter int CDB_N   = 2,
    localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int OCC_W  = $clog2(ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [TAG_W-1:0]          alloc_tag1,
    input  logic [TAG_W-1:0]          alloc_tag2,
    input  logic                      alloc_rdy1,
    input  logic                      alloc_rdy2,
    input  logic [DATA_W-1:0]         alloc_val1,
    input  logic [DATA_W-1:0]         alloc_val2,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [IDX_W-1:0]          issue_idx,
    output logic [DATA_W-1:0]         issue_val1,
    output logic [DATA_W-1:0]         issue_val2,
    output logic [OCC_W-1:0]          occupancy
);

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] dat;
    } cdb_hit_t;

    // Scan channels high to low so the lowest matching channel overrides.
    function automatic cdb_hit_t cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_N-1:0]        vld,
        input logic [CDB_N*TAG_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] data
    );
        cdb_hit_t r;
        r.hit = 1'b0;
        r.dat = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                r.hit = 1'b1;
                r.dat = data[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // Entry state
    logic [ENTRIES-1:0] ent_vld;
    logic [ENTRIES-1:0] ent_rdy1;
    logic [ENTRIES-1:0] ent_rdy2;
    logic [TAG_W-1:0]   ent_tag1 [ENTRIES];
    logic [TAG_W-1:0]   ent_tag2 [ENTRIES];
    logic [DATA_W-1:0]  ent_val1 [ENTRIES];
    logic [DATA_W-1:0]  ent_val2 [ENTRIES];

    logic               lock_vld;
    logic [IDX_W-1:0]   lock_idx;
    logic [OCC_W-1:0]   occ_q;

    cdb_hit_t           wk1 [ENTRIES];
    cdb_hit_t           wk2 [ENTRIES];
    cdb_hit_t           byp1;
    cdb_hit_t           byp2;

    logic [ENTRIES-1:0] cand;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic               alloc_fire;
    logic               issue_fire;

    assign alloc_ready = ~(&ent_vld);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign cand        = ent_vld & ent_rdy1 & ent_rdy2;
    assign issue_valid = |cand;
    assign issue_fire  = issue_valid && issue_ready;
    // A locked entry stays a candidate: ready sources never change and only issue clears valid.
    assign sel_idx     = lock_vld ? lock_idx : first_idx;
    assign occupancy   = occ_q;

    always_comb begin
        byp1 = cdb_lookup(alloc_tag1, cdb_valid, cdb_tag, cdb_data);
        byp2 = cdb_lookup(alloc_tag2, cdb_valid, cdb_tag, cdb_data);
        for (int e = 0; e < ENTRIES; e++) begin
            wk1[e] = cdb_lookup(ent_tag1[e], cdb_valid, cdb_tag, cdb_data);
            wk2[e] = cdb_lookup(ent_tag2[e], cdb_valid, cdb_tag, cdb_data);
        end
    end

    // Lowest-index free entry and lowest-index candidate (descending scan, last write wins).
    always_comb begin
        alloc_idx = '0;
        first_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (!ent_vld[e]) alloc_idx = IDX_W'(e);
            if (cand[e])     first_idx = IDX_W'(e);
        end
    end

    always_comb begin
        issue_idx  = '0;
        issue_val1 = '0;
        issue_val2 = '0;
        if (issue_valid) begin
            issue_idx  = sel_idx;
            issue_val1 = ent_val1[sel_idx];
            issue_val2 = ent_val2[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_vld  <= '0;
            ent_rdy1 <= '0;
            ent_rdy2 <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                ent_tag1[e] <= '0;
                ent_tag2[e] <= '0;
                ent_val1[e] <= '0;
                ent_val2[e] <= '0;
            end
            lock_vld <= 1'b0;
            lock_idx <= '0;
            occ_q    <= '0;
        end else begin
            // Wakeup of waiting sources in valid entries.
            for (int e = 0; e < ENTRIES; e++) begin
                if (ent_vld[e]) begin
                    if (!ent_rdy1[e] && wk1[e].hit) begin
                        ent_rdy1[e] <= 1'b1;
                        ent_val1[e] <= wk1[e].dat;
                    end
                    if (!ent_rdy2[e] && wk2[e].hit) begin
                        ent_rdy2[e] <= 1'b1;
                        ent_val2[e] <= wk2[e].dat;
                    end
                end
            end

            // The issued entry is valid while the alloc target is free, so they never collide.
            if (issue_fire) ent_vld[sel_idx] <= 1'b0;

            if (alloc_fire) begin
                ent_vld[alloc_idx]  <= 1'b1;
                ent_tag1[alloc_idx] <= alloc_tag1;
                ent_tag2[alloc_idx] <= alloc_tag2;
                ent_rdy1[alloc_idx] <= alloc_rdy1 | byp1.hit;
                ent_rdy2[alloc_idx] <= alloc_rdy2 | byp2.hit;
                ent_val1[alloc_idx] <= alloc_rdy1 ? alloc_val1 : byp1.dat;
                ent_val2[alloc_idx] <= alloc_rdy2 ? alloc_val2 : byp2.dat;
            end

            if (issue_fire) begin
                lock_vld <= 1'b0;
            end else if (issue_valid) begin
                lock_vld <= 1'b1;
                lock_idx <= sel_idx;
            end

            case ({alloc_fire, issue_fire})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_wakeup_array.sv
// Purpose: self-checking bench for tag_wakeup_array (vector table plus directed corner sequences).
// Latency: inputs driven 1ns after the rising edge, outputs compared on the falling edge.
// Backpressure: issue_ready is driven per vector to exercise lock hold and release.
module tb_tag_wakeup_array;

    logic        clk;
    logic        reset_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [5:0]  alloc_tag1, alloc_tag2;
    logic        alloc_rdy1, alloc_rdy2;
    logic [31:0] alloc_val1, alloc_val2;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [63:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_idx;
    logic [31:0] issue_val1, issue_val2;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    tag_wakeup_array #(
        .TAG_W(6), .DATA_W(32), .ENTRIES(4), .CDB_N(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
        .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
        .alloc_val1(alloc_val1), .alloc_val2(alloc_val2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_idx(issue_idx), .issue_val1(issue_val1), .issue_val2(issue_val2),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [5:0]  t1, t2;
        logic        r1, r2;
        logic [31:0] v1, v2;
        logic [1:0]  cv;
        logic [5:0]  ct0, ct1;
        logic [31:0] cd0, cd1;
        logic        ir;
        logic        e_iv;
        logic [1:0]  e_idx;
        logic [31:0] e_v1, e_v2;
        logic [2:0]  e_occ;
        logic        e_ar;
    } vec_t;

    function automatic vec_t mk(
        input logic av, input logic [5:0] t1, input logic [5:0] t2,
        input logic r1, input logic r2, input logic [31:0] v1, input logic [31:0] v2,
        input logic [1:0] cv, input logic [5:0] ct0, input logic [5:0] ct1,
        input logic [31:0] cd0, input logic [31:0] cd1, input logic ir,
        input logic e_iv, input logic [1:0] e_idx, input logic [31:0] e_v1,
        input logic [31:0] e_v2, input logic [2:0] e_occ, input logic e_ar
    );
        vec_t v;
        v.av = av; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2; v.v1 = v1; v.v2 = v2;
        v.cv = cv; v.ct0 = ct0; v.ct1 = ct1; v.cd0 = cd0; v.cd1 = cd1; v.ir = ir;
        v.e_iv = e_iv; v.e_idx = e_idx; v.e_v1 = e_v1; v.e_v2 = e_v2;
        v.e_occ = e_occ; v.e_ar = e_ar;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic iv, input logic [1:0] idx,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic [2:0] occ, input logic ar);
        chk({nm, ".issue_valid"}, {31'd0, issue_valid}, {31'd0, iv});
        chk({nm, ".issue_idx"},   {30'd0, issue_idx},   {30'd0, idx});
        chk({nm, ".issue_val1"},  issue_val1, v1);
        chk({nm, ".issue_val2"},  issue_val2, v2);
        chk({nm, ".occupancy"},   {29'd0, occupancy},   {29'd0, occ});
        chk({nm, ".alloc_ready"}, {31'd0, alloc_ready}, {31'd0, ar});
    endtask

    task automatic drive(input logic av, input logic [5:0] t1, input logic [5:0] t2,
                         input logic r1, input logic r2, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [1:0] cv,
                         input logic [5:0] ct0, input logic [5:0] ct1,
                         input logic [31:0] cd0, input logic [31:0] cd1, input logic ir);
        alloc_valid = av; alloc_tag1 = t1; alloc_tag2 = t2;
        alloc_rdy1 = r1; alloc_rdy2 = r2; alloc_val1 = v1; alloc_val2 = v2;
        cdb_valid = cv; cdb_tag = {ct1, ct0}; cdb_data = {cd1, cd0};
        issue_ready = ir;
    endtask

    task automatic idle(input logic ir);
        drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, ir);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vt [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              av    t1     t2     r1    r2    v1             v2      cv     ct0    ct1    cd0            cd1            ir   | iv    idx    v1             v2             occ   ar
        vt[0]  = mk(1'b1, 6'd5, 6'd9, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        vt[1]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 6'd5, 6'd0, 32'hAAAA_0001, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd1, 1'b1);
        vt[2]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 6'd0, 6'd9, 32'd0, 32'hBBBB_0002, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd1, 1'b1);
        vt[3]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd0, 32'hAAAA_0001, 32'hBBBB_0002, 3'd1, 1'b1);
        vt[4]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd0, 32'hAAAA_0001, 32'hBBBB_0002, 3'd1, 1'b1);
        vt[5]  = mk(1'b1, 6'd7, 6'd0, 1'b0, 1'b1, 32'd0, 32'h55, 2'b01, 6'd7, 6'd0, 32'h1234, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        vt[6]  = mk(1'b1, 6'd3, 6'd4, 1'b0, 1'b1, 32'd0, 32'h99, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd0, 32'h1234, 32'h55, 3'd1, 1'b1);
        vt[7]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b11, 6'd3, 6'd3, 32'h11, 32'h22, 1'b0, 1'b1, 2'd0, 32'h1234, 32'h55, 3'd2, 1'b1);
        vt[8]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd0, 32'h1234, 32'h55, 3'd2, 1'b1);
        vt[9]  = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd0, 32'h1234, 32'h55, 3'd2, 1'b1);
        vt[10] = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd1, 32'h11, 32'h99, 3'd1, 1'b1);
        vt[11] = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1, 2'd1, 32'h11, 32'h99, 3'd1, 1'b1);
        vt[12] = mk(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);

        reset_n = 1'b0;
        idle(1'b0);
        #3;
        check_out("reset", 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: each row's expectation is the state built by the rows before it.
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vt[i].av, vt[i].t1, vt[i].t2, vt[i].r1, vt[i].r2, vt[i].v1, vt[i].v2,
                  vt[i].cv, vt[i].ct0, vt[i].ct1, vt[i].cd0, vt[i].cd1, vt[i].ir);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vt[i].e_iv, vt[i].e_idx, vt[i].e_v1,
                      vt[i].e_v2, vt[i].e_occ, vt[i].e_ar);
        end

        // Fill all four entries; entry 2 arrives ready and gets locked while stalled.
        next_cycle();
        drive(1'b1, 6'd10, 6'd0, 1'b0, 1'b1, 32'd0, 32'h100, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check_out("fill0", 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        next_cycle();
        drive(1'b1, 6'd11, 6'd0, 1'b0, 1'b1, 32'd0, 32'h101, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check_out("fill1", 1'b0, 2'd0, 32'd0, 32'd0, 3'd1, 1'b1);
        next_cycle();
        drive(1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h2001, 32'h2002, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check_out("fill2", 1'b0, 2'd0, 32'd0, 32'd0, 3'd2, 1'b1);
        next_cycle();
        drive(1'b1, 6'd12, 6'd0, 1'b0, 1'b1, 32'd0, 32'h103, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check_out("fill3", 1'b1, 2'd2, 32'h2001, 32'h2002, 3'd3, 1'b1);

        // Full: alloc attempt is ignored; entry 0 wakes up underneath the lock.
        next_cycle();
        drive(1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 2'b01, 6'd10, 6'd0, 32'h3000, 32'd0, 1'b0);
        @(negedge clk);
        check_out("full", 1'b1, 2'd2, 32'h2001, 32'h2002, 3'd4, 1'b0);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        check_out("lock_hold", 1'b1, 2'd2, 32'h2001, 32'h2002, 3'd4, 1'b0);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_out("lock_accept", 1'b1, 2'd2, 32'h2001, 32'h2002, 3'd4, 1'b0);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        check_out("after_accept", 1'b1, 2'd0, 32'h3000, 32'h100, 3'd3, 1'b1);

        // Simultaneous alloc and issue: entry 0 issues, the new entry lands in free entry 2.
        next_cycle();
        drive(1'b1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h4001, 32'h4002, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        check_out("both_fire", 1'b1, 2'd0, 32'h3000, 32'h100, 3'd3, 1'b1);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        check_out("after_both", 1'b1, 2'd2, 32'h4001, 32'h4002, 3'd3, 1'b1);

        // Reset pulsed between edges while entries are pending.
        next_cycle();
        idle(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(1'b1);
        @(negedge clk);
        check_out("rst_release", 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        check_out("post_rst", 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
